// File: rtl/ram_arbiter.sv
// Two-requester access controller for the 256x8 main memory; sequences ram_sa/ram_s/ram_e and the bus enable.
// Optional build macro RAM_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 wins ties) instead of round-robin.
module ram_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_sa,
    output logic              ram_s,
    output logic              ram_e,
    output logic [DATA_W-1:0] ram_bus_out,
    output logic              ram_bus_oe,
    input  logic [DATA_W-1:0] ram_bus_in
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_WR      = 3'd2,
        S_WR_HOLD = 3'd3,
        S_RD      = 3'd4,
        S_ACK     = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_grant;
    logic                w_sel;
    logic                w_arb_sel;
    logic                r_we;
    logic                r_owner;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;

`ifdef RAM_ARB_FIXED_PRIO_EN
    assign w_arb_sel = ~req0;
`else
    logic r_last;

    // Last-grant pointer: the requester not granted last wins a tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (w_grant) begin
            r_last <= w_sel;
        end
    end

    assign w_arb_sel = (req0 && req1) ? ~r_last : req1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        w_sel   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req0 || req1) begin
                    w_grant = 1'b1;
                    w_sel   = w_arb_sel;
                    w_next  = S_ADDR;
                end
            end
            S_ADDR:    w_next = r_we ? S_WR : S_RD;
            S_WR:      w_next = S_WR_HOLD;
            S_WR_HOLD: w_next = S_ACK;
            S_RD:      w_next = S_ACK;
            S_ACK:     w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Capture the winner's request and the read result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_owner <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_grant) begin
                r_we    <= w_sel ? we1 : we0;
                r_owner <= w_sel;
                r_addr  <= w_sel ? addr1 : addr0;
                r_wdata <= w_sel ? wdata1 : wdata0;
            end
            if (r_state == S_RD) begin
                r_rdata <= ram_bus_in;
            end
        end
    end

    // Strobes are decoded from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_sa      <= 1'b0;
            ram_s       <= 1'b0;
            ram_e       <= 1'b0;
            ram_bus_oe  <= 1'b0;
            ram_bus_out <= '0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            ram_sa      <= (w_next == S_ADDR);
            ram_s       <= (w_next == S_WR);
            ram_e       <= (w_next == S_RD);
            ram_bus_oe  <= (w_next == S_WR) || (w_next == S_WR_HOLD);
            ram_bus_out <= ((w_next == S_WR) || (w_next == S_WR_HOLD)) ? r_wdata : '0;
            ack0        <= (w_next == S_ACK) && !r_owner;
            ack1        <= (w_next == S_ACK) && r_owner;
            busy        <= (w_next != S_IDLE);
        end
    end

    assign ram_a = r_addr;
    assign rdata = r_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: transaction-level reference model plus a behavioural 256x8 memory on the bus side.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [7:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic       ack0, ack1, busy, ram_sa, ram_s, ram_e, ram_bus_oe;
    logic [7:0] rdata, ram_a, ram_bus_out, ram_bus_in;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on = 1'b0;

    ram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
        .ram_a(ram_a), .ram_sa(ram_sa), .ram_s(ram_s), .ram_e(ram_e),
        .ram_bus_out(ram_bus_out), .ram_bus_oe(ram_bus_oe), .ram_bus_in(ram_bus_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural memory device: address register loaded by ram_sa, written by ram_s.
    logic [7:0] dev_mem [256];
    logic [7:0] dev_areg = '0;
    always @(posedge clk) begin
        if (ram_sa) dev_areg <= ram_a;
        if (ram_s)  dev_mem[dev_areg] <= ram_bus_out;
    end
    assign ram_bus_in = ram_e ? dev_mem[dev_areg] : 8'h00;

    // Reference model: one access at a time, k = cycles elapsed since the grant edge.
    logic [7:0] m_mem [256];
    bit         m_active = 1'b0;
    int         m_k = 0;
    bit         m_we = 1'b0, m_owner = 1'b0, m_last = 1'b1;
    logic [7:0] m_addr = '0, m_wdata = '0, m_rdata = '0;

    initial begin
        for (int i = 0; i < 256; i++) begin
            dev_mem[i] = 8'(i * 7 + 3);
            m_mem[i]   = 8'(i * 7 + 3);
        end
    end

    function automatic int lat(input bit we);
        return we ? 4 : 3;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0; m_k = 0; m_last = 1'b1; m_rdata = 8'h00;
        end else if (m_active) begin
            if (m_k == lat(m_we)) begin
                if (m_we) m_mem[m_addr] = m_wdata;
                m_active = 1'b0;
            end else begin
                m_k++;
                if (!m_we && m_k == 3) m_rdata = m_mem[m_addr];
            end
        end else if (req0 || req1) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            m_owner = !req0;
`else
            m_owner = (req0 && req1) ? !m_last : req1;
`endif
            m_last   = m_owner;
            m_we     = m_owner ? we1 : we0;
            m_addr   = m_owner ? addr1 : addr0;
            m_wdata  = m_owner ? wdata1 : wdata0;
            m_active = 1'b1;
            m_k      = 1;
        end
    end

    // Every-cycle comparison against the model plus bus-protocol rules.
    always @(negedge clk) begin
        if (chk_on) begin
            bit e_oe;
            e_oe = m_active && m_we && (m_k == 2 || m_k == 3);
            chk("busy",   32'(busy),       32'(m_active));
            chk("ram_sa", 32'(ram_sa),     32'(m_active && m_k == 1));
            chk("ram_s",  32'(ram_s),      32'(m_active && m_we && m_k == 2));
            chk("ram_e",  32'(ram_e),      32'(m_active && !m_we && m_k == 2));
            chk("ram_oe", 32'(ram_bus_oe), 32'(e_oe));
            chk("ack0",   32'(ack0),       32'(m_active && m_k == lat(m_we) && !m_owner));
            chk("ack1",   32'(ack1),       32'(m_active && m_k == lat(m_we) && m_owner));
            chk("rdata",  32'(rdata),      32'(m_rdata));
            if (m_active) chk("ram_a", 32'(ram_a), 32'(m_addr));
            if (e_oe)     chk("bus_out", 32'(ram_bus_out), 32'(m_wdata));
            chk("excl_e_oe",   32'(ram_e && ram_bus_oe), 32'd0);
            chk("excl_strobe", 32'((2'(ram_sa) + 2'(ram_s) + 2'(ram_e)) > 2'd1), 32'd0);
            chk("excl_ack",    32'(ack0 && ack1), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int         seen [$];
    int         exp_owner;
    logic [7:0] ra;

    initial begin
        #2 rst_n = 1'b0;
        chk_on = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_oe", 32'(ram_bus_oe), 32'd0);

        // Single write 0xA5 -> 0x3C from requester 0
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h3C; wdata0 = 8'hA5;
        tick();
        chk("wr_sa", 32'(ram_sa), 32'd1);
        chk("wr_a", 32'(ram_a), 32'h3C);
        tick();
        chk("wr_s", 32'(ram_s), 32'd1);
        chk("wr_oe1", 32'(ram_bus_oe), 32'd1);
        chk("wr_data", 32'(ram_bus_out), 32'hA5);
        tick();
        chk("wr_hold_s", 32'(ram_s), 32'd0);
        chk("wr_oe2", 32'(ram_bus_oe), 32'd1);
        tick();
        chk("wr_ack0", 32'(ack0), 32'd1);
        req0 = 1'b0;
        tick();
        chk("wr_idle", 32'(busy), 32'd0);

        // Read-back of 0x3C by requester 1
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h3C;
        tick();
        chk("rd_sa", 32'(ram_sa), 32'd1);
        tick();
        chk("rd_e", 32'(ram_e), 32'd1);
        chk("rd_oe", 32'(ram_bus_oe), 32'd0);
        tick();
        chk("rd_ack1", 32'(ack1), 32'd1);
        chk("rd_data", 32'(rdata), 32'hA5);
        req1 = 1'b0;
        tick();
        tick();
        chk("rd_hold", 32'(rdata), 32'hA5);

        // Sustained contention: reads of 0x00 and 0xFF held high
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h00;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'hFF;
        for (int c = 0; c < 40 && seen.size() < 4; c++) begin
            tick();
            if (ack0) seen.push_back(0);
            if (ack1) seen.push_back(1);
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("cont_count", 32'(seen.size()), 32'd4);
        for (int i = 0; i < seen.size(); i++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            exp_owner = 0;
`else
            exp_owner = i % 2;
`endif
            chk("cont_owner", 32'(seen[i]), 32'(exp_owner));
        end
        tick();
        tick();

        // Reset asserted during WR
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; wdata0 = 8'h77;
        tick();
        tick();
        chk("rst_mid_s_before", 32'(ram_s), 32'd1);
        #1 rst_n = 1'b0;
        req0 = 1'b0;
        #1;
        chk("rst_mid_s", 32'(ram_s), 32'd0);
        chk("rst_mid_oe", 32'(ram_bus_oe), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Service after reset: write 0x33 -> 0x20, read it back
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h20; wdata1 = 8'h33;
        repeat (4) tick();
        chk("post_wr_ack1", 32'(ack1), 32'd1);
        req1 = 1'b0;
        tick();
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h20;
        repeat (3) tick();
        chk("post_rd_ack0", 32'(ack0), 32'd1);
        chk("post_rd_data", 32'(rdata), 32'h33);
        req0 = 1'b0;
        tick();

        // Random traffic; each requester holds req until it sees its ack
        for (int c = 0; c < 600; c++) begin
            tick();
            if (req0 && ack0) req0 = 1'b0;
            else if (!req0 && $urandom_range(0, 2) == 0) begin
                ra = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
                req0 = 1'b1; we0 = 1'($urandom_range(0, 1)); addr0 = ra; wdata0 = 8'($urandom);
            end
            if (req1 && ack1) req1 = 1'b0;
            else if (!req1 && $urandom_range(0, 2) == 0) begin
                ra = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 7));
                req1 = 1'b1; we1 = 1'($urandom_range(0, 1)); addr1 = ra; wdata1 = 8'($urandom);
            end
        end
        for (int c = 0; c < 20 && (req0 || req1); c++) begin
            tick();
            if (ack0) req0 = 1'b0;
            if (ack1) req1 = 1'b0;
        end
        chk("drain_reqs", 32'(req0 || req1), 32'd0);
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) tick();
        chk("drain_idle", 32'(busy), 32'd0);

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port access controller for the 256×8 main memory. It arbitrates between two requesters, such as the CPU fetch/execute path and a program loader or DMA engine. It sequences the memory's address-set, write and read-enable strobes so the data bus is never driven by two sources at once. The block sits between the requesters and the memory/bus, and owns every memory control strobe.

## Interface

Parameters:
- ADDR_W, 8, memory address width
- DATA_W, 8, data width

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- req0 / req1  input  1  access request from requester 0 / 1
- we0 / we1  input  1  1 = write, 0 = read; sampled at grant
- addr0 / addr1  input  ADDR_W  access address; sampled at grant
- wdata0 / wdata1  input  DATA_W  write data; sampled at grant
- ack0 / ack1  output  1  one-cycle completion pulse
- rdata  output  DATA_W  read result; valid in the ack cycle, held until the next read completes
- busy  output  1  high whenever the state is not IDLE
- ram_a  output  ADDR_W  memory address
- ram_sa  output  1  set the memory address register
- ram_s  output  1  write strobe
- ram_e  output  1  read enable
- ram_bus_out  output  DATA_W  write data toward the shared bus
- ram_bus_oe  output  1  tristate enable for ram_bus_out; the top level drives the bus only when this is 1
- ram_bus_in  input  DATA_W  shared-bus value for reads

## Operation

FSM states: IDLE, ADDR, WR, WR_HOLD, RD, ACK.

- **IDLE**
  - If any request is high, choose a winner. Capture its we, addr and wdata into internal registers. Record the winner as the grant owner and go to ADDR.
  - If no request is high, stay in IDLE.
- **ADDR**
  - ram_a = captured address; ram_sa = 1.
  - Go to WR if the captured we = 1, otherwise go to RD.
- **WR**
  - ram_s = 1; ram_bus_oe = 1; ram_bus_out = captured wdata.
  - Go to WR_HOLD.
- **WR_HOLD**
  - ram_s = 0; ram_bus_oe stays 1 with the same data, giving hold time for the level-sensitive memory.
  - Go to ACK.
- **RD**
  - ram_e = 1; ram_bus_oe = 0.
  - rdata ← ram_bus_in at the rising edge that leaves RD.
  - Go to ACK.
- **ACK**
  - ack of the grant owner = 1; all memory strobes = 0.
  - Go to IDLE.
- **Strobe exclusivity:** ram_a holds the captured address in every state from ADDR through ACK. ram_sa, ram_s and ram_e are never high in the same cycle. ram_e and ram_bus_oe are never high in the same cycle.
- **Arbitration:** default is round-robin.
  - If both requests are high in IDLE, the requester not granted last wins.
  - The last-grant pointer resets to 1, so requester 0 wins the first tie.
  - A lone request always wins.
- **Request protocol:** a requester holds req until it sees its ack.
  - A req still high in the IDLE cycle after ACK counts as a new request.
  - Request inputs are ignored outside IDLE.
- **Addresses:** used as-is, with no increment. 0xFF and 0x00 need no special handling.

## Timing

- **Reset values:** state IDLE; ack0 = ack1 = 0; busy = 0; all ram_* outputs = 0, including ram_bus_oe; rdata = 0; pointer = 1.
- **Reset is asynchronous:** asserting rst_n mid-access deasserts ram_s, ram_e and ram_bus_oe immediately. No ack is issued for the aborted access, and memory contents are undefined at the aborted address.
- Req sampled high at edge N (state IDLE):
  - Write: ADDR in cycle N+1, WR in N+2, WR_HOLD in N+3, ack in N+4. Write latency = 4 cycles.
  - Read: ADDR in N+1, RD in N+2, ack with rdata in N+3. Read latency = 3 cycles.
- **Throughput:** minimum gap between acks is 5 cycles (write) or 4 cycles (read), including one IDLE cycle.
- **Simultaneous events:**
  - A request arriving during busy waits, with no loss.
  - The other requester's req rising in the ACK cycle is seen in the following IDLE cycle.

## Configuration

- **RAM_ARB_FIXED_PRIO_EN defined:** fixed priority. Requester 0 always wins ties, and the last-grant pointer is not implemented.
- **RAM_ARB_FIXED_PRIO_EN not defined:** round-robin as in Operation.
- All latencies are identical in both builds.

## Test plan

- **Single write:** req0 with we0 = 1, addr0 = 0x3C, wdata0 = 0xA5 -> ram_sa pulses for 1 cycle, then ram_s for 1 cycle with ram_bus_oe high for 2 cycles; ack0 arrives 4 cycles after the sampled request.
- **Read-back:** req1 read of 0x3C after the write -> ram_e high for 1 cycle, ack1 3 cycles after the sampled request, rdata = 0xA5 held afterwards.
- **Sustained contention:** req0 and req1 both held high, issuing reads at 0x00 and 0xFF -> grants alternate 0, 1, 0, 1. Default build only.
- **Fixed priority:** same sustained stimulus with RAM_ARB_FIXED_PRIO_EN defined -> requester 0 wins every tie.
- **Reset mid-write:** rst_n low during WR -> in the same cycle ram_s = 0, ram_bus_oe = 0, busy = 0; no ack; the next request is served normally.
- **Protocol checker, every cycle across random traffic:**
  - never ram_e together with ram_bus_oe;
  - never two of ram_sa, ram_s, ram_e high together;
  - never ack0 together with ack1;
  - ram_a stable from ADDR through ACK.
